act_sweep_checker: RTL and testbench

Self-checking stimulus/response engine for the sequential activation units (leaky ReLU and friends) in the activation-function library. It drives every 2's-complement input code exhaustively into the unit under test through a valid-tagged data bus. It consumes the unit's valid-tagged output stream at the other end, compares each result in order against an internal golden model, and reports pass/fail plus first-failure diagnostics. It is synthesizable and is used both in simulation and in on-FPGA bring-up.

---
 rtl/act_sweep_checker.sv | 175 +++++++++++++++++
 tb/tb_act_sweep_checker.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/act_sweep_checker.sv
// rtl/act_sweep_checker.sv - exhaustive stimulus/response checker for sequential activation units
// Drives every input code, compares in-order responses with a golden ReLU/leaky-ReLU model.
module act_sweep_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 1,
  parameter int LEAKY      = 1,
  parameter int NEG_SHIFT  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_en,
  output logic [DATA_WIDTH-1:0] o_stim_data,
  output logic                  o_stim_valid,
  input  logic [DATA_WIDTH-1:0] i_resp_data,
  input  logic                  i_resp_valid,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_cnt,
  output logic [DATA_WIDTH-1:0] o_first_err_stim,
  output logic [DATA_WIDTH-1:0] o_first_err_resp
);
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = $clog2(LATENCY + 2);
  localparam int DEPTH = 1 << AW;
  localparam int TMO   = 4 * (LATENCY + 1);
  localparam int TW    = $clog2(TMO + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DW-1:0] CODE_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] CODE_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]      state;
  logic [DW-1:0]   cnt;
  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic [TW-1:0]   tmo_cnt;

  function automatic logic [DW-1:0] golden(input logic [DW-1:0] x);
    logic signed [DW-1:0] sx;
    sx = $signed(x) >>> NEG_SHIFT;
    if (!x[DW-1])       return x;
    else if (LEAKY != 0) return sx;
    else                 return '0;
  endfunction

  logic            start_go, issue, push, pop, fifo_empty, fifo_full;
  logic            resp_act, resp_err, tmo_exp, drain_clear;
  logic [DW-1:0]   stim_next, head_stim, head_exp;
  logic [AW-1:0]   wr_addr;
  logic [AW:0]     err_add;
  logic [16:0]     err_sum;

  always_comb begin
    fifo_empty  = (fifo_cnt == '0);
    fifo_full   = fifo_cnt[AW];
    start_go    = (state == S_IDLE) && i_start;
    issue       = (state == S_SWEEP) && i_en && !fifo_full;
    push        = start_go || issue;
    stim_next   = start_go ? CODE_MIN : cnt;
    wr_addr     = start_go ? '0 : wr_ptr;
    head_stim   = mem[rd_ptr][2*DW-1:DW];
    head_exp    = mem[rd_ptr][DW-1:0];
    drain_clear = fifo_empty && !i_resp_valid;
    tmo_exp     = (state == S_DRAIN) && !drain_clear && (tmo_cnt == TW'(TMO - 1));
    resp_act    = (state != S_IDLE) && i_resp_valid && !tmo_exp;
    pop         = resp_act && !fifo_empty;
    resp_err    = resp_act && (fifo_empty || (head_exp != i_resp_data));
    // On timeout every entry still outstanding is a missing response.
    err_add     = tmo_exp ? fifo_cnt : {{AW{1'b0}}, resp_err};
    err_sum     = {1'b0, o_err_cnt} + {{(16-AW){1'b0}}, err_add};
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= {stim_next, golden(stim_next)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      tmo_cnt          <= '0;
      o_stim_data      <= '0;
      o_stim_valid     <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_cnt        <= '0;
      o_first_err_stim <= '0;
      o_first_err_resp <= '0;
    end else begin
      o_done       <= 1'b0;
      o_stim_valid <= 1'b0;

      if (start_go) begin
        wr_ptr   <= AW'(1);
        rd_ptr   <= '0;
        fifo_cnt <= {{AW{1'b0}}, 1'b1};
      end else if (tmo_exp) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + {{AW{1'b0}}, 1'b1};
          2'b01:   fifo_cnt <= fifo_cnt - {{AW{1'b0}}, 1'b1};
          default: fifo_cnt <= fifo_cnt;
        endcase
      end

      if (start_go) begin
        o_err_cnt        <= '0;
        o_first_err_stim <= '0;
        o_first_err_resp <= '0;
      end else begin
        if (err_add != '0) o_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (resp_err && (o_err_cnt == '0)) begin
          o_first_err_stim <= fifo_empty ? '0 : head_stim;
          o_first_err_resp <= i_resp_data;
        end
      end

      case (state)
        S_IDLE: begin
          if (i_start) begin
            // The first code goes out on the start edge so there is no bubble.
            state        <= S_SWEEP;
            o_busy       <= 1'b1;
            o_pass       <= 1'b0;
            o_stim_data  <= CODE_MIN;
            o_stim_valid <= 1'b1;
            cnt          <= CODE_MIN + ONE;
            tmo_cnt      <= '0;
          end
        end
        S_SWEEP: begin
          if (issue) begin
            o_stim_data  <= cnt;
            o_stim_valid <= 1'b1;
            cnt          <= cnt + ONE;
            if (cnt == CODE_MAX) begin
              state   <= S_DRAIN;
              tmo_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          if (drain_clear || tmo_exp) begin
            state  <= S_DONE;
            o_busy <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          o_done <= 1'b1;
          o_pass <= (o_err_cnt == '0);
          state  <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_act_sweep_checker.sv
// tb/tb_act_sweep_checker.sv - directed bench for act_sweep_checker with a unit model and scoreboard
module tb_act_sweep_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_en = 1'b0;
  logic [7:0]  stim_data, resp_data = 8'h00;
  logic        stim_valid, resp_valid = 1'b0;
  logic        busy, done, pass;
  logic [15:0] err_cnt;
  logic [7:0]  fes, fer;

  logic        start_p = 1'b0, en_p = 1'b1;
  logic [7:0]  stim_data_p, resp_data_p = 8'h00;
  logic        stim_valid_p, resp_valid_p = 1'b0;
  logic        busy_p, done_p, pass_p;
  logic [15:0] err_cnt_p;
  logic [7:0]  fes_p, fer_p;

  always #5 clk = ~clk;

  act_sweep_checker #(.DATA_WIDTH(8), .LATENCY(1), .LEAKY(1), .NEG_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_en(i_en),
    .o_stim_data(stim_data), .o_stim_valid(stim_valid),
    .i_resp_data(resp_data), .i_resp_valid(resp_valid),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err_cnt),
    .o_first_err_stim(fes), .o_first_err_resp(fer));

  act_sweep_checker #(.DATA_WIDTH(8), .LATENCY(1), .LEAKY(0), .NEG_SHIFT(3)) dut_plain (
    .clk(clk), .rst_n(rst_n), .i_start(start_p), .i_en(en_p),
    .o_stim_data(stim_data_p), .o_stim_valid(stim_valid_p),
    .i_resp_data(resp_data_p), .i_resp_valid(resp_valid_p),
    .o_busy(busy_p), .o_done(done_p), .o_pass(pass_p), .o_err_cnt(err_cnt_p),
    .o_first_err_stim(fes_p), .o_first_err_resp(fer_p));

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Golden value by integer arithmetic: floor division by 8 for negatives.
  function automatic int model_y(input int x, input bit leaky);
    if (x >= 0) return x;
    if (!leaky) return 0;
    return (x - 7) / 8;
  endfunction

  bit corrupt_f0 = 0, drop_7f = 0, spur_mode = 0;
  always begin : unit_leaky
    logic       sv, nv, prev_sv;
    logic [7:0] sd, nd, prev_sd;
    logic signed [7:0] s;
    prev_sv = 0; prev_sd = 0;
    forever begin
      @(negedge clk);
      sv = stim_valid; sd = stim_data; s = sd;
      nv = sv;
      nd = s[7] ? 8'(s >>> 3) : sd;
      if (corrupt_f0 && sv && sd == 8'hF0) nd = 8'h00;
      if (drop_7f && sv && sd == 8'h7F) nv = 1'b0;
      if (spur_mode && !sv && prev_sv && prev_sd == 8'h7F) begin
        nv = 1'b1; nd = 8'h55; spur_mode = 0;
      end
      if (!rst_n) nv = 1'b0;
      prev_sv = sv; prev_sd = sd;
      @(posedge clk); #1;
      resp_valid = nv; resp_data = nd;
    end
  end

  always begin : unit_plain
    logic       sv;
    logic [7:0] sd;
    @(negedge clk);
    sv = stim_valid_p; sd = stim_data_p;
    @(posedge clk); #1;
    resp_valid_p = sv; resp_data_p = sd[7] ? 8'h00 : sd;
  end

  logic [15:0] q[$];
  logic [7:0]  exp_stim, m_fs, m_fr, exp_p;
  int          stim_cnt, m_err, start_cyc, done_lat, total, stim_cnt_p;
  bit          active = 0, have_first, sweep_done, active_p = 0, done_seen_p;

  always @(negedge clk) begin : scoreboard
    logic [15:0] e;
    if (!rst_n) begin
      check("rst_stim_valid", stim_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_first_stim", fes, 0);
      check("rst_first_resp", fer, 0);
      active = 0;
      q.delete();
    end else if (active) begin
      if (!drop_7f) check("err_cnt_track", err_cnt, m_err);
      if (stim_valid) begin
        if (stim_cnt == 0) begin
          check("first_stim_latency", cyc - start_cyc, 0);
          check("pass_cleared", pass, 0);
        end
        check("stim_seq", stim_data, exp_stim);
        q.push_back({stim_data, 8'(model_y(int'($signed(stim_data)), 1'b1))});
        exp_stim++;
        stim_cnt++;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          e = {8'h00, resp_data ^ 8'hFF};
        end else begin
          e = q.pop_front();
        end
        if (e[7:0] != resp_data) begin
          m_err++;
          if (!have_first) begin
            have_first = 1; m_fs = e[15:8]; m_fr = resp_data;
          end
        end
      end
      if (done) begin
        total = m_err + q.size();
        if (total > 65535) total = 65535;
        check("done_err_cnt", err_cnt, total);
        check("done_pass", pass, total == 0);
        check("done_stim_count", stim_cnt, 256);
        if (have_first) begin
          check("done_first_stim", fes, m_fs);
          check("done_first_resp", fer, m_fr);
        end
        done_lat = cyc - start_cyc;
        sweep_done = 1;
        active = 0;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin : scoreboard_plain
    if (rst_n && active_p) begin
      if (stim_valid_p) begin
        check("plain_stim_seq", stim_data_p, exp_p);
        exp_p++;
        stim_cnt_p++;
      end
      if (done_p) begin
        check("plain_pass", pass_p, 1);
        check("plain_err_cnt", err_cnt_p, 0);
        check("plain_stim_count", stim_cnt_p, 256);
        done_seen_p = 1;
        active_p = 0;
      end
    end
  end

  task automatic start_sweep();
    @(posedge clk); #1;
    i_start = 1; i_en = 1;
    @(posedge clk); #1;
    i_start = 0;
    start_cyc = cyc; exp_stim = 8'h80; stim_cnt = 0; m_err = 0;
    have_first = 0; sweep_done = 0; q.delete(); active = 1;
  endtask

  task automatic wait_done(input string name, input bit toggle);
    for (int i = 0; i < 1000 && !sweep_done; i++) begin
      @(posedge clk); #1;
      if (toggle) i_en = ~i_en;
    end
    check({name, "_done_seen"}, sweep_done, 1);
    i_en = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    start_sweep();
    wait_done("ideal", 0);
    check("ideal_pass", pass, 1);
    check("ideal_err_cnt", err_cnt, 16'd0);
    check("ideal_done_bound", done_lat <= 259, 1);

    corrupt_f0 = 1;
    start_sweep();
    wait_done("corrupt", 0);
    corrupt_f0 = 0;
    check("corrupt_err_cnt", err_cnt, 16'd1);
    check("corrupt_first_stim", fes, 8'hF0);
    check("corrupt_first_resp", fer, 8'h00);
    check("corrupt_pass", pass, 0);

    drop_7f = 1;
    start_sweep();
    wait_done("drop", 0);
    check("drop_err_cnt", err_cnt, 16'd1);
    check("drop_pass", pass, 0);
    check("drop_timeout_window", (done_lat > 259) && (done_lat <= 267), 1);
    drop_7f = 0;

    start_sweep();
    wait_done("toggle", 1);
    check("toggle_pass", pass, 1);
    check("toggle_err_cnt", err_cnt, 16'd0);
    check("toggle_length", done_lat >= 500, 1);

    start_sweep();
    repeat (50) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_stim_valid", stim_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    start_sweep();
    wait_done("after_reset", 0);
    check("after_reset_pass", pass, 1);

    spur_mode = 1;
    start_sweep();
    wait_done("spur", 0);
    check("spur_err_cnt", err_cnt, 16'd1);
    check("spur_first_stim", fes, 8'h00);
    check("spur_first_resp", fer, 8'h55);
    check("spur_pass", pass, 0);

    @(posedge clk); #1;
    start_p = 1;
    @(posedge clk); #1;
    start_p = 0; exp_p = 8'h80; stim_cnt_p = 0; done_seen_p = 0; active_p = 1;
    for (int i = 0; i < 1000 && !done_seen_p; i++) @(posedge clk);
    check("plain_done_seen", done_seen_p, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
